// File: rtl/fifo_package.sv
// ---------------------------------------------------------------------------
// fifo_package
//   Shared definitions for the parity FIFO and its write-side arbiter.
//   - WIDTH / DATA_WIDTH : payload width and stored word width (payload+parity)
//   - PARITY_BIT         : default parity position, "MSB" or "LSB"
//   - PARITY_TYPE        : default parity sense, "EVEN" or "ODD"
//   - fifo_word_t        : one stored FIFO word
//   - calc_parity()      : parity bit for a payload
//   - pack_word()        : payload plus parity placed at the chosen end
// ---------------------------------------------------------------------------
package fifo_package;

    localparam int    WIDTH       = 32;
    localparam int    DATA_WIDTH  = WIDTH + 1;
    localparam string PARITY_BIT  = "MSB";
    localparam string PARITY_TYPE = "EVEN";

    typedef logic [DATA_WIDTH-1:0] fifo_word_t;

    // EVEN: the parity bit makes the total count of ones even.
    // ODD : the parity bit makes the total count of ones odd.
    function automatic logic calc_parity(input logic [WIDTH-1:0] d,
                                         input logic             odd);
        return odd ? ~^d : ^d;
    endfunction

    function automatic fifo_word_t pack_word(input logic [WIDTH-1:0] d,
                                             input logic             lsb,
                                             input logic             odd);
        logic p;
        p = calc_parity(d, odd);
        return lsb ? {d, p} : {p, d};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin grant selection over N_REQ requesters. The pointer holds the
//   index of the last winner; the search starts one past it and wraps.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     req          per-requester request vector
//     advance      move the pointer to the current grant (accepted handshake)
//     gnt_onehot   one-hot grant, all zero when nobody requests
//     gnt_idx      index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic                       advance,
    output logic [N_REQ-1:0]           gnt_onehot,
    output logic [$clog2(N_REQ)-1:0]   gnt_idx
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] ptr;
    logic          found;
    int            cand;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        // Offsets 1..N_REQ visit every requester once, last winner last.
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (!found && req[IW'(cand)]) begin
                found   = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
        gnt_onehot = found ? (N_REQ'(1) << gnt_idx) : '0;
    end

    // Reset value N_REQ-1 gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(N_REQ - 1);
        end else if (advance) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the parity FIFO write port between N_REQ valid/ready producers.
//   The winning payload is packed with its parity bit into a one-entry output
//   register, which is written into the FIFO as soon as it is not full. A new
//   word may load in the same cycle the held one drains, so a stream runs at
//   one word per cycle.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     req_valid_i     per-requester valid
//     req_data_i      payloads, requester k at [k*WIDTH +: WIDTH]
//     req_ready_o     one-hot accept, handshake = valid & ready
//     fifo_full_i     FIFO full flag
//     fifo_wr_en_o    FIFO write strobe
//     fifo_wr_data_o  payload plus parity bit
//     fifo_src_o      requester index of fifo_wr_data_o
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int    N_REQ       = 4,
    parameter int    WIDTH       = fifo_package::WIDTH,
    parameter string PARITY_BIT  = fifo_package::PARITY_BIT,
    parameter string PARITY_TYPE = fifo_package::PARITY_TYPE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*WIDTH-1:0]     req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    input  logic                       fifo_full_i,
    output logic                       fifo_wr_en_o,
    output logic [WIDTH:0]             fifo_wr_data_o,
    output logic [$clog2(N_REQ)-1:0]   fifo_src_o
);

    import fifo_package::*;

    localparam int   IW     = $clog2(N_REQ);
    localparam logic IS_LSB = (PARITY_BIT == "LSB");
    localparam logic IS_ODD = (PARITY_TYPE == "ODD");

    logic             out_valid_q;
    logic             drain;
    logic             load;
    logic [N_REQ-1:0] gnt_onehot;
    logic [IW-1:0]    gnt_idx;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH:0]   packed_word;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_valid_i),
        .advance    (load),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    assign drain        = out_valid_q & ~fifo_full_i;
    assign fifo_wr_en_o = drain;

    // rst_n gates the accept so nothing is granted while reset is held.
    assign load        = rst_n & (|req_valid_i) & (~out_valid_q | drain);
    assign req_ready_o = load ? gnt_onehot : '0;

    assign sel_data = req_data_i[int'(gnt_idx)*WIDTH +: WIDTH];

    // The shared packing helper is sized for the package width; other widths
    // pack locally with the same rule.
    generate
        if (WIDTH == fifo_package::WIDTH) begin : g_pkg_pack
            always_comb packed_word = pack_word(sel_data, IS_LSB, IS_ODD);
        end else begin : g_local_pack
            logic par;
            always_comb begin
                par         = IS_ODD ? ~^sel_data : ^sel_data;
                packed_word = IS_LSB ? {sel_data, par} : {par, sel_data};
            end
        end
    endgenerate

    // Output register: loads on handshake, holds under full, empties on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            fifo_wr_data_o <= '0;
            fifo_src_o     <= '0;
        end else if (load) begin
            out_valid_q    <= 1'b1;
            fifo_wr_data_o <= packed_word;
            fifo_src_o     <= gnt_idx;
        end else if (drain) begin
            out_valid_q    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   valid;
    logic [127:0] data;
    logic         full;

    logic [3:0]   ready_em, ready_ol, ready_el;
    logic         wr_em, wr_ol, wr_el;
    logic [32:0]  wd_em, wd_ol, wd_el;
    logic [1:0]   src_em, src_ol, src_el;

    int n_cmp = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(4), .WIDTH(32), .PARITY_BIT("MSB"), .PARITY_TYPE("EVEN")) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid), .req_data_i(data),
        .req_ready_o(ready_em), .fifo_full_i(full), .fifo_wr_en_o(wr_em),
        .fifo_wr_data_o(wd_em), .fifo_src_o(src_em));

    fifo_wr_arbiter #(.N_REQ(4), .WIDTH(32), .PARITY_BIT("LSB"), .PARITY_TYPE("ODD")) dut_ol (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid), .req_data_i(data),
        .req_ready_o(ready_ol), .fifo_full_i(full), .fifo_wr_en_o(wr_ol),
        .fifo_wr_data_o(wd_ol), .fifo_src_o(src_ol));

    fifo_wr_arbiter #(.N_REQ(4), .WIDTH(32), .PARITY_BIT("LSB"), .PARITY_TYPE("EVEN")) dut_el (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid), .req_data_i(data),
        .req_ready_o(ready_el), .fifo_full_i(full), .fifo_wr_en_o(wr_el),
        .fifo_wr_data_o(wd_el), .fifo_src_o(src_el));

    typedef struct packed {
        logic        rst_n;
        logic [3:0]  valid;
        logic        full;
        logic [31:0] dbase;
        logic [3:0]  ready;
        logic        wr_en;
        logic [32:0] word;
        logic [1:0]  src;
    } vec_t;

    vec_t tbl[27];

    // Reference model state
    bit          m_held;
    int          m_ptr;
    int          m_src;
    logic [32:0] m_w_em, m_w_ol, m_w_el;

    function automatic vec_t v(input logic r, input logic [3:0] vl, input logic f,
                               input logic [31:0] db, input logic [3:0] rd,
                               input logic we, input logic [32:0] w, input logic [1:0] s);
        vec_t t;
        t.rst_n = r; t.valid = vl; t.full = f; t.dbase = db;
        t.ready = rd; t.wr_en = we; t.word = w; t.src = s;
        return t;
    endfunction

    // Parity from a ones count: the stored word must hold an even (EVEN) or
    // odd (ODD) number of ones in total.
    function automatic logic [32:0] exp_word(input logic [31:0] d, input bit odd, input bit lsb);
        int   ones;
        logic p;
        ones = $countones(d);
        p = ((ones % 2) == 1) ? ~odd : odd;
        return lsb ? {d, p} : {p, d};
    endfunction

    // First requesting index after the last winner, wrapping; -1 if none.
    function automatic int pick(input logic [3:0] vl, input int last);
        for (int off = 1; off <= 4; off++) begin
            if (vl[(last + off) % 4]) return (last + off) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int k = 0; k < 4; k++) data[k*32 +: 32] = base ^ (32'(k) << 8);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; valid = '0; full = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_held = 0; m_ptr = 3; m_src = 0;
        m_w_em = '0; m_w_ol = '0; m_w_el = '0;
    endtask

    initial begin
        rst_n = 1'b0; valid = '0; full = 1'b0; data = '0;

        // Directed rows: reset, single requester, full rotation, full stall
        // and release, lone requester 2, reset while holding under full.
        tbl[0]  = v(0, 4'b0001, 0, 32'h3,  4'b0000, 0, 33'h0,          2'd0);
        tbl[1]  = v(1, 4'b0001, 0, 32'h3,  4'b0001, 0, 33'h0,          2'd0);
        tbl[2]  = v(1, 4'b0000, 0, 32'h3,  4'b0000, 1, 33'h0_0000_0003, 2'd0);
        tbl[3]  = v(1, 4'b0000, 0, 32'h3,  4'b0000, 0, 33'h0_0000_0003, 2'd0);
        tbl[4]  = v(0, 4'b1111, 0, 32'h10, 4'b0000, 0, 33'h0,          2'd0);
        tbl[5]  = v(1, 4'b1111, 0, 32'h10, 4'b0001, 0, 33'h0,          2'd0);
        tbl[6]  = v(1, 4'b1111, 0, 32'h10, 4'b0010, 1, 33'h1_0000_0010, 2'd0);
        tbl[7]  = v(1, 4'b1111, 0, 32'h10, 4'b0100, 1, 33'h0_0000_0110, 2'd1);
        tbl[8]  = v(1, 4'b1111, 0, 32'h10, 4'b1000, 1, 33'h0_0000_0210, 2'd2);
        tbl[9]  = v(1, 4'b1111, 0, 32'h10, 4'b0001, 1, 33'h1_0000_0310, 2'd3);
        for (int i = 10; i < 15; i++)
            tbl[i] = v(1, 4'b1111, 1, 32'h10, 4'b0000, 0, 33'h1_0000_0010, 2'd0);
        tbl[15] = v(1, 4'b1111, 0, 32'h10, 4'b0010, 1, 33'h1_0000_0010, 2'd0);
        tbl[16] = v(1, 4'b0000, 0, 32'h10, 4'b0000, 1, 33'h0_0000_0110, 2'd1);
        tbl[17] = v(1, 4'b0000, 0, 32'h10, 4'b0000, 0, 33'h0_0000_0110, 2'd1);
        tbl[18] = v(1, 4'b0100, 0, 32'h10, 4'b0100, 0, 33'h0_0000_0110, 2'd1);
        tbl[19] = v(1, 4'b0100, 0, 32'h10, 4'b0100, 1, 33'h0_0000_0210, 2'd2);
        tbl[20] = v(1, 4'b0100, 0, 32'h10, 4'b0100, 1, 33'h0_0000_0210, 2'd2);
        tbl[21] = v(1, 4'b0000, 0, 32'h10, 4'b0000, 1, 33'h0_0000_0210, 2'd2);
        tbl[22] = v(1, 4'b0010, 1, 32'h10, 4'b0010, 0, 33'h0_0000_0210, 2'd2);
        tbl[23] = v(1, 4'b0000, 1, 32'h10, 4'b0000, 0, 33'h0_0000_0110, 2'd1);
        tbl[24] = v(0, 4'b1111, 1, 32'h10, 4'b0000, 0, 33'h0,          2'd0);
        tbl[25] = v(1, 4'b1111, 0, 32'h10, 4'b0001, 0, 33'h0,          2'd0);
        tbl[26] = v(1, 4'b0000, 0, 32'h10, 4'b0000, 1, 33'h1_0000_0010, 2'd0);

        for (int i = 0; i < 27; i++) begin
            @(posedge clk); #1;
            rst_n = tbl[i].rst_n; valid = tbl[i].valid; full = tbl[i].full;
            set_data(tbl[i].dbase);
            @(negedge clk);
            check($sformatf("row%0d ready", i), 64'(ready_em), 64'(tbl[i].ready));
            check($sformatf("row%0d wr_en", i), 64'(wr_em),    64'(tbl[i].wr_en));
            check($sformatf("row%0d data", i),  64'(wd_em),    64'(tbl[i].word));
            check($sformatf("row%0d src", i),   64'(src_em),   64'(tbl[i].src));
        end

        // All-ones payload through each parity configuration.
        do_reset();
        @(posedge clk); #1;
        valid = 4'b0001; data = '0; data[31:0] = 32'hFFFF_FFFF;
        @(negedge clk);
        check("ones ready", 64'(ready_ol), 64'(4'b0001));
        @(posedge clk); #1;
        valid = 4'b0000;
        @(negedge clk);
        check("ones wr_en odd/lsb", 64'(wr_ol), 64'(1'b1));
        check("ones data odd/lsb",  64'(wd_ol), 64'(33'h1_FFFF_FFFF));
        check("ones data even/lsb", 64'(wd_el), 64'(33'h1_FFFF_FFFE));
        check("ones data even/msb", 64'(wd_em), 64'(33'h0_FFFF_FFFF));

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int         g;
            logic [3:0] exp_ready;
            logic       exp_wr;
            bit         can_take;
            @(posedge clk); #1;
            valid = 4'($urandom_range(0, 15));
            if (c % 50 < 10) valid = 4'b1111;
            full = ($urandom_range(0, 9) < 3);
            for (int k = 0; k < 4; k++) data[k*32 +: 32] = $urandom;
            @(negedge clk);
            can_take  = !m_held || !full;
            g         = pick(valid, m_ptr);
            exp_wr    = m_held && !full;
            exp_ready = (can_take && g >= 0) ? 4'(1 << g) : 4'b0000;
            check("rnd ready",         64'(ready_em), 64'(exp_ready));
            check("rnd wr_en",         64'(wr_em),    64'(exp_wr));
            check("rnd data even/msb", 64'(wd_em),    64'(m_w_em));
            check("rnd data odd/lsb",  64'(wd_ol),    64'(m_w_ol));
            check("rnd data even/lsb", 64'(wd_el),    64'(m_w_el));
            check("rnd src",           64'(src_em),   64'(m_src));
            if (can_take && g >= 0) begin
                m_held = 1;
                m_src  = g;
                m_ptr  = g;
                m_w_em = exp_word(data[g*32 +: 32], 0, 0);
                m_w_ol = exp_word(data[g*32 +: 32], 1, 1);
                m_w_el = exp_word(data[g*32 +: 32], 0, 1);
            end else if (exp_wr) begin
                m_held = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
